// File: rtl/hdc_pkg.sv
// Shared constants and types for the class hypervector training datapath.
// Geometry is fixed here so the ALU, the accumulator and its users agree.
package hdc_pkg;

  localparam int DIMS_PER_CC      = 1024;
  localparam int BITWIDTH_PER_DIM = 9;
  localparam int NUM_CLASSES      = 26;
  localparam int NUM_CHUNKS       = 8;
  localparam int ADDR_W           = $clog2(NUM_CLASSES * NUM_CHUNKS);
  localparam int CLASS_W          = $clog2(NUM_CLASSES);
  localparam int CHUNK_W          = $clog2(NUM_CHUNKS);
  localparam int SAT_W            = $clog2(DIMS_PER_CC) + 1;
  localparam int CHUNK_BITS       = DIMS_PER_CC * BITWIDTH_PER_DIM;

  typedef enum logic [1:0] {
    OP_BUNDLE   = 2'd0,
    OP_BINARIZE = 2'd1,
    OP_LOAD     = 2'd2
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  typedef logic [BITWIDTH_PER_DIM-1:0] dim_acc_t;
  typedef dim_acc_t [DIMS_PER_CC-1:0]  chunk_acc_t;

  function automatic logic [ADDR_W-1:0] chunk_addr(input logic [CLASS_W-1:0] cls,
                                                    input logic [CHUNK_W-1:0] idx);
    return ADDR_W'(cls) * ADDR_W'(NUM_CHUNKS) + ADDR_W'(idx);
  endfunction

endpackage

// File: rtl/chunk_update_alu.sv
// Combinational per-dimension update of one class chunk: saturating bundle,
// threshold binarize or load, plus a count of dimensions that saturated.
module chunk_update_alu
  import hdc_pkg::*;
(
  input  logic [1:0]                  i_op,
  input  logic [CHUNK_BITS-1:0]       i_stored,
  input  logic [DIMS_PER_CC-1:0]      i_hv,
  input  logic [BITWIDTH_PER_DIM-1:0] i_threshold,
  output logic [CHUNK_BITS-1:0]       o_result,
  output logic [SAT_W-1:0]            o_sat_count
);

  chunk_acc_t              w_stored;
  chunk_acc_t              w_result;
  logic [DIMS_PER_CC-1:0]  w_sat_bits;
  logic [SAT_W-1:0]        w_sat_count;

  assign w_stored = i_stored;

  // Per-dimension update; a dim saturates only when it is already all-ones and gets a 1.
  always_comb begin
    w_result   = {CHUNK_BITS{1'b0}};
    w_sat_bits = {DIMS_PER_CC{1'b0}};
    for (int i = 0; i < DIMS_PER_CC; i++) begin
      case (i_op)
        OP_BUNDLE: begin
          w_sat_bits[i] = (&w_stored[i]) & i_hv[i];
          if (w_sat_bits[i]) begin
            w_result[i] = {BITWIDTH_PER_DIM{1'b1}};
          end else begin
            w_result[i] = w_stored[i] + {{(BITWIDTH_PER_DIM-1){1'b0}}, i_hv[i]};
          end
        end
        OP_BINARIZE: w_result[i] = {{(BITWIDTH_PER_DIM-1){1'b0}}, (w_stored[i] >= i_threshold)};
        default:     w_result[i] = {{(BITWIDTH_PER_DIM-1){1'b0}}, i_hv[i]};
      endcase
    end
  end

  // Population count of saturation events.
  always_comb begin
    w_sat_count = {SAT_W{1'b0}};
    for (int i = 0; i < DIMS_PER_CC; i++) begin
      w_sat_count = w_sat_count + {{(SAT_W-1){1'b0}}, w_sat_bits[i]};
    end
  end

  assign o_result    = w_result;
  assign o_sat_count = w_sat_count;

endmodule

// File: rtl/class_hv_accumulator.sv
// Read-modify-write sequencer for class hypervector chunks in external memory.
// One request at a time: IDLE -> READ -> WAIT -> WRITE, or IDLE -> WRITE for loads.
module class_hv_accumulator
  import hdc_pkg::*;
(
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [1:0]                  in_op,
  input  logic [CLASS_W-1:0]          in_class,
  input  logic [CHUNK_W-1:0]          in_chunk_idx,
  input  logic [DIMS_PER_CC-1:0]      in_hv_chunk,
  input  logic [BITWIDTH_PER_DIM-1:0] bin_threshold,
  output logic                        mem_rd_en,
  output logic                        mem_wr_en,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic [CHUNK_BITS-1:0]       mem_rd_data,
  output logic [CHUNK_BITS-1:0]       mem_wr_data,
  output logic                        done,
  output logic [SAT_W-1:0]            sat_count
);

  state_t                      r_state;
  logic                        r_ready;
  logic                        r_rd_en;
  logic                        r_wr_en;
  logic                        r_done;
  logic [ADDR_W-1:0]           r_addr;
  logic [CHUNK_BITS-1:0]       r_wr_data;
  logic [SAT_W-1:0]            r_sat;
  logic [1:0]                  r_op;
  logic [DIMS_PER_CC-1:0]      r_hv;
  logic [BITWIDTH_PER_DIM-1:0] r_thr;

  logic [1:0]                  w_alu_op;
  logic [DIMS_PER_CC-1:0]      w_alu_hv;
  logic [CHUNK_BITS-1:0]       w_alu_result;
  logic [SAT_W-1:0]            w_alu_sat;
  logic                        w_class_ok;
  logic                        w_needs_read;

  assign w_class_ok   = (in_class < CLASS_W'(NUM_CLASSES));
  assign w_needs_read = (in_op == OP_BUNDLE) || (in_op == OP_BINARIZE);

  // Loads are computed straight from the request at accept time; others from the captured request.
  always_comb begin
    w_alu_op = OP_LOAD;
    w_alu_hv = in_hv_chunk;
    if (r_state == ST_IDLE) begin
      w_alu_op = OP_LOAD;
      w_alu_hv = in_hv_chunk;
    end else begin
      w_alu_op = r_op;
      w_alu_hv = r_hv;
    end
  end

  chunk_update_alu u_alu (
    .i_op        (w_alu_op),
    .i_stored    (mem_rd_data),
    .i_hv        (w_alu_hv),
    .i_threshold (r_thr),
    .o_result    (w_alu_result),
    .o_sat_count (w_alu_sat)
  );

  // Request sequencer with registered strobes and result.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= ST_IDLE;
      r_ready   <= 1'b1;
      r_rd_en   <= 1'b0;
      r_wr_en   <= 1'b0;
      r_done    <= 1'b0;
      r_addr    <= {ADDR_W{1'b0}};
      r_wr_data <= {CHUNK_BITS{1'b0}};
      r_sat     <= {SAT_W{1'b0}};
      r_op      <= OP_BUNDLE;
      r_hv      <= {DIMS_PER_CC{1'b0}};
      r_thr     <= {BITWIDTH_PER_DIM{1'b0}};
    end else begin
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_ready <= 1'b0;
            r_hv    <= in_hv_chunk;
            r_thr   <= bin_threshold;
            // Out-of-range class: complete as a no-op without touching memory.
            if (!w_class_ok) begin
              r_state <= ST_WRITE;
              r_done  <= 1'b1;
            end else if (w_needs_read) begin
              r_addr  <= chunk_addr(in_class, in_chunk_idx);
              r_op    <= in_op;
              r_state <= ST_READ;
              r_rd_en <= 1'b1;
            end else begin
              r_addr    <= chunk_addr(in_class, in_chunk_idx);
              r_wr_data <= w_alu_result;
              r_state   <= ST_WRITE;
              r_wr_en   <= 1'b1;
              r_done    <= 1'b1;
            end
          end
        end
        ST_READ: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_wr_data <= w_alu_result;
          if (r_op == OP_BUNDLE) begin
            r_sat <= w_alu_sat;
          end
          r_state <= ST_WRITE;
          r_wr_en <= 1'b1;
          r_done  <= 1'b1;
        end
        ST_WRITE: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready    = r_ready;
  assign mem_rd_en   = r_rd_en;
  assign mem_wr_en   = r_wr_en;
  assign mem_addr    = r_addr;
  assign mem_wr_data = r_wr_data;
  assign done        = r_done;
  assign sat_count   = r_sat;

endmodule

// File: doc/class_hv_accumulator.md
Name: class_hv_accumulator

Overview:
- Sequential successor to the combinational class bundler; owns the read-modify-write of class hypervector chunks held in external class memory.
- Per accepted request: reads the stored chunk for (class, chunk), then either saturating-adds an encoded binary HV chunk (bundle), thresholds it to 0/1 per dim (binarize), or overwrites it (load).
- Sits between the encoder/chunk sequencer and the class-HV SRAM wrapper in the training datapath.

Parameters:
- DIMS_PER_CC, 1024, dimensions processed per chunk.
- BITWIDTH_PER_DIM, 9, unsigned accumulator width per dimension.
- NUM_CLASSES, 26, number of class HVs.
- NUM_CHUNKS, 8, chunks per HV (total D = DIMS_PER_CC*NUM_CHUNKS).
- ADDR_W, $clog2(NUM_CLASSES*NUM_CHUNKS), memory address width (derived).

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- in_op  in  2  0=BUNDLE, 1=BINARIZE, 2=LOAD, 3=reserved (treated as LOAD)
- in_class  in  $clog2(NUM_CLASSES)  target class
- in_chunk_idx  in  $clog2(NUM_CHUNKS)  target chunk
- in_hv_chunk  in  DIMS_PER_CC  encoded binary HV chunk
- bin_threshold  in  BITWIDTH_PER_DIM  binarize threshold, sampled on accept
- mem_rd_en  out  1  class memory read strobe
- mem_wr_en  out  1  class memory write strobe
- mem_addr  out  ADDR_W  in_class*NUM_CHUNKS + in_chunk_idx
- mem_rd_data  in  DIMS_PER_CC*BITWIDTH_PER_DIM  stored chunk, valid 1 cycle after mem_rd_en
- mem_wr_data  out  DIMS_PER_CC*BITWIDTH_PER_DIM  updated chunk
- done  out  1  one-cycle pulse coincident with mem_wr_en
- sat_count  out  $clog2(DIMS_PER_CC)+1  dims that saturated in the last BUNDLE; held until next BUNDLE write

Behaviour:
- Interface: one clock, clk; reset asynchronous, active-low, nrst.
- Reset (any time, including mid-operation): state IDLE; in_ready=1; mem_rd_en, mem_wr_en, done=0; mem_addr, mem_wr_data, sat_count=0; captured request discarded, no write issued.
- FSM states: IDLE, READ, WAIT, WRITE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture op, address, chunk and threshold. BUNDLE/BINARIZE -> READ; LOAD -> WRITE.
- READ: mem_rd_en=1 for one cycle, mem_addr driven -> WAIT.
- WAIT: capture mem_rd_data, compute result into register -> WRITE.
- WRITE: mem_wr_en=1 and done=1 for one cycle, mem_addr unchanged -> IDLE.
- in_ready=0 in every state except IDLE. No back-to-back overlap: next accept earliest cycle after WRITE.
- Latency from accept edge: BUNDLE/BINARIZE write on 4th cycle; LOAD write on 2nd cycle.
- mem_rd_en and mem_wr_en never high together. mem_addr holds its value from accept until exit from WRITE.
- BUNDLE: per dim i, out[i] = min(stored[i] + hv[i], 2^BITWIDTH_PER_DIM-1). Saturation when stored[i] is all-ones and hv[i]=1. sat_count = popcount of saturation events, updated at WRITE.
- BINARIZE: out[i] = {zeros, (stored[i] >= threshold)}; input HV ignored. sat_count unchanged.
- LOAD: out[i] = zero-extended hv[i] (first sample initialises class).
- in_class >= NUM_CLASSES: request accepted and completed as a no-op. No mem strobes. done pulses in the cycle after accept.
- Inputs other than in_valid are don't-care when not accepting.

Decomposition:
- Shared package hdc_pkg: DIMS_PER_CC, BITWIDTH_PER_DIM, NUM_CLASSES, NUM_CHUNKS, op enum (OP_BUNDLE, OP_BINARIZE, OP_LOAD), dim_acc_t and chunk_acc_t typedefs.
- One sub-module, chunk_update_alu: combinational per-dim saturating add / threshold / load plus saturation popcount. The FSM and registers live in the top.

Test Plan:
- LOAD class 3 chunk 2 with hv=all-ones -> mem_addr=26, no mem_rd_en, mem_wr_en and done at cycle 2, every dim of mem_wr_data = 1.
- BUNDLE class 0 chunk 0, mem_rd_data all dims=5, hv alternating 1/0 -> mem_wr_data alternating 6/5, sat_count=0, write on cycle 4.
- BUNDLE with stored dims=511 and hv=all-ones -> mem_wr_data all 511, sat_count=1024.
- BINARIZE with threshold=4, stored dims alternating 3/4 -> mem_wr_data alternating 0/1, sat_count held from the prior value.
- in_valid held high for two requests -> second accepted only after done. in_ready low across READ/WAIT/WRITE.
- Assert nrst low during WAIT -> mem_wr_en stays 0, all outputs 0, in_ready=1 after release. in_class=30 -> no mem strobes, done 1 cycle after accept.
